// File: rtl/gate_selftest_ctrl.sv
// Self-test sequencer for a 2-input gate: applies all four input vectors,
// compares the gate output against EXPECT. Optional macro: ERR_CAPTURE_EN.
module gate_selftest_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECT        = 4'b0111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       gate_a,
    output logic       gate_b,
    input  logic       gate_c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [1:0] fail_vec,
    output logic [2:0] fail_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] mis_q, mis_d;
    logic       pass_q, pass_d;

`ifdef ERR_CAPTURE_EN
    logic [1:0] fv_q, fv_d;
    logic [2:0] fc_q, fc_d;

    function automatic logic [1:0] first_set(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    function automatic logic [2:0] pop4(input logic [3:0] m);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 4; i++) begin
            c = c + {2'b00, m[i]};
        end
        return c;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        pass_d  = pass_q;
`ifdef ERR_CAPTURE_EN
        fv_d    = fv_q;
        fc_d    = fc_q;
`endif
        busy    = 1'b0;
        done    = 1'b0;
        gate_a  = 1'b0;
        gate_b  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    idx_d   = 2'd0;
                    cnt_d   = 4'd0;
                    mis_d   = 4'd0;
                end
            end
            SETTLE: begin
                busy              = 1'b1;
                {gate_a, gate_b}  = idx_q;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            CHECK: begin
                busy             = 1'b1;
                {gate_a, gate_b} = idx_q;
                mis_d[idx_q]     = mis_q[idx_q] | (gate_c != EXPECT[idx_q]);
                if (idx_q == 2'd3) begin
                    state_d = DONE;
                    pass_d  = (mis_d == 4'd0);
`ifdef ERR_CAPTURE_EN
                    fv_d    = first_set(mis_d);
                    fc_d    = pop4(mis_d);
`endif
                end else begin
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = 4'd0;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            mis_q   <= 4'd0;
            pass_q  <= 1'b0;
`ifdef ERR_CAPTURE_EN
            fv_q    <= 2'd0;
            fc_q    <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            pass_q  <= pass_d;
`ifdef ERR_CAPTURE_EN
            fv_q    <= fv_d;
            fc_q    <= fc_d;
`endif
        end
    end

    assign pass = pass_q;

`ifdef ERR_CAPTURE_EN
    assign fail_vec = fv_q;
    assign fail_cnt = fc_q;
`else
    assign fail_vec = 2'd0;
    assign fail_cnt = 3'd0;
`endif

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Scoreboard bench for gate_selftest_ctrl: default instance with a
// mode-selectable gate model, plus a SETTLE_CYCLES=1 instance.
module tb_gate_selftest_ctrl;

    typedef struct {
        logic       pass;
        logic [1:0] fv;
        logic [2:0] fc;
        int         cyc;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t prev;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, start0, a0, b0, c0, busy0, done0, pass0;
    logic [1:0] fv0;
    logic [2:0] fc0;
    int         mode0 = 0;

    logic       rst1, start1, a1, b1, c1, busy1, done1, pass1;
    logic [1:0] fv1;
    logic [2:0] fc1;

    // mode 0 = good NAND, 1 = stuck-at-1, 2 = stuck-at-0
    assign c0 = (mode0 == 0) ? ~(a0 & b0) :
                (mode0 == 1) ? 1'b1 : 1'b0;
    assign c1 = ~(a1 & b1);

    gate_selftest_ctrl u0 (
        .clk(clk), .rst(rst0), .start(start0),
        .gate_a(a0), .gate_b(b0), .gate_c(c0),
        .busy(busy0), .done(done0), .pass(pass0),
        .fail_vec(fv0), .fail_cnt(fc0)
    );

    gate_selftest_ctrl #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst(rst1), .start(start1),
        .gate_a(a1), .gate_b(b1), .gate_c(c1),
        .busy(busy1), .done(done1), .pass(pass1),
        .fail_vec(fv1), .fail_cnt(fc1)
    );

    function automatic exp_t model(input int mode, input int cyc);
        exp_t       e;
        logic [3:0] exp_tt;
        logic       obs;
        logic       hit;
        exp_tt = 4'b0111;
        e.pass = 1'b1;
        e.fv   = 2'd0;
        e.fc   = 3'd0;
        e.cyc  = cyc;
        hit    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            obs = (mode == 0) ? ~(i[1] & i[0]) : (mode == 1);
            if (obs != exp_tt[i]) begin
                e.pass = 1'b0;
                e.fc   = e.fc + 3'd1;
                if (!hit) e.fv = 2'(i);
                hit = 1'b1;
            end
        end
`ifndef ERR_CAPTURE_EN
        e.fv = 2'd0;
        e.fc = 3'd0;
`endif
        return e;
    endfunction

    // Drives one run on u0 (start at cycle 0) and observes 20 cycles.
    task automatic run0(input int mode, input bit extra,
                        output int lat, output bit vec_ok,
                        output logic [5:0] snap, output int ndone);
        mode0  = mode;
        vec_ok = 1'b1;
        lat    = -1;
        ndone  = 0;
        snap   = '0;
        @(negedge clk);
        start0 = 1'b1;
        sb0.push_back(model(mode, 13));
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k <= 12) begin
                if ({a0, b0} !== 2'((k - 1) / 3) || busy0 !== 1'b1)
                    vec_ok = 1'b0;
            end
            if (k == 6) snap = {pass0, fv0, fc0};
            if (done0 === 1'b1) begin
                ndone++;
                if (lat < 0) lat = k;
            end
            start0 = extra && (k == 4 || k == 8);
        end
    endtask

    task automatic test_reset();
        rst0 = 1'b1; start0 = 1'b1;
        rst1 = 1'b1; start1 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy0, done0, pass0, a0, b0, fv0, fc0} !== 10'd0) begin
            errors++;
            $display("FAIL reset_u0: got %b want 0",
                     {busy0, done0, pass0, a0, b0, fv0, fc0});
        end
        checks++;
        if ({busy1, done1, pass1, a1, b1, fv1, fc1} !== 10'd0) begin
            errors++;
            $display("FAIL reset_u1: got %b want 0",
                     {busy1, done1, pass1, a1, b1, fv1, fc1});
        end
        rst0 = 1'b0; start0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fault_modes();
        int         lat, nd;
        bit         vok;
        logic [5:0] snap;
        exp_t       e;
        for (int m = 0; m < 3; m++) begin
            run0(m, 1'b0, lat, vok, snap, nd);
            checks++;
            if (sb0.size() == 0) begin
                errors++;
                $display("FAIL sb_empty mode%0d", m);
                continue;
            end
            e = sb0.pop_front();
            prev = e;
            if (lat !== e.cyc || nd !== 1) begin
                errors++;
                $display("FAIL latency mode%0d: got %0d (n=%0d) want %0d",
                         m, lat, nd, e.cyc);
            end
            checks++;
            if (!vok) begin
                errors++;
                $display("FAIL vector_seq mode%0d: got bad want 00,01,10,11", m);
            end
            checks++;
            if ({pass0, fv0, fc0} !== {e.pass, e.fv, e.fc}) begin
                errors++;
                $display("FAIL result mode%0d: got %b/%0d/%0d want %b/%0d/%0d",
                         m, pass0, fv0, fc0, e.pass, e.fv, e.fc);
            end
        end
    endtask

    task automatic test_hold();
        int         lat, nd;
        bit         vok;
        logic [5:0] snap;
        exp_t       e;
        run0(0, 1'b0, lat, vok, snap, nd);
        checks++;
        if (snap !== {prev.pass, prev.fv, prev.fc}) begin
            errors++;
            $display("FAIL hold_midrun: got %b want %b",
                     snap, {prev.pass, prev.fv, prev.fc});
        end
        e = sb0.pop_front();
        checks++;
        if (lat !== e.cyc || pass0 !== e.pass) begin
            errors++;
            $display("FAIL hold_rerun: got lat %0d pass %b want %0d %b",
                     lat, pass0, e.cyc, e.pass);
        end
    endtask

    task automatic test_ignore_start();
        int         lat, nd;
        bit         vok;
        logic [5:0] snap;
        exp_t       e;
        run0(0, 1'b1, lat, vok, snap, nd);
        e = sb0.pop_front();
        checks++;
        if (lat !== e.cyc || nd !== 1 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: got lat %0d n=%0d busy %b want %0d 1 0",
                     lat, nd, busy0, e.cyc);
        end
    endtask

    task automatic test_reset_midrun();
        int         lat, nd;
        bit         vok;
        logic [5:0] snap;
        exp_t       e;
        int         spur;
        mode0 = 0;
        @(negedge clk);
        start0 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            start0 = 1'b0;
        end
        rst0 = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy0, a0, b0, done0} !== 4'd0) begin
            errors++;
            $display("FAIL rst_midrun: got %b want 0000",
                     {busy0, a0, b0, done0});
        end
        rst0 = 1'b0;
        spur = 0;
        repeat (16) begin
            @(negedge clk);
            if (done0 === 1'b1 || busy0 === 1'b1) spur++;
        end
        checks++;
        if (spur != 0) begin
            errors++;
            $display("FAIL rst_no_done: got %0d active cycles want 0", spur);
        end
        rst0 = 1'b1; start0 = 1'b1;
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL rst_priority: got busy %b want 0", busy0);
        end
        rst0 = 1'b0; start0 = 1'b0;
        run0(0, 1'b0, lat, vok, snap, nd);
        e = sb0.pop_front();
        checks++;
        if (lat !== e.cyc || pass0 !== e.pass) begin
            errors++;
            $display("FAIL rst_rerun: got lat %0d pass %b want %0d %b",
                     lat, pass0, e.cyc, e.pass);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        @(negedge clk);
        start1 = 1'b1;
        sb1.push_back(model(0, 9));
        sb1.push_back(model(0, 19));
        sb1.push_back(model(0, 29));
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (done1 === 1'b1) begin
                checks++;
                if (sb1.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra_done: got done at %0d want none", k);
                end else begin
                    e = sb1.pop_front();
                    if (k != e.cyc || pass1 !== e.pass) begin
                        errors++;
                        $display("FAIL b2b_done: got cyc %0d pass %b want %0d %b",
                                 k, pass1, e.cyc, e.pass);
                    end
                end
            end
        end
        start1 = 1'b0;
        checks++;
        if (sb1.size() != 0) begin
            errors++;
            $display("FAIL b2b_missing: got %0d pending want 0", sb1.size());
        end
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        test_reset();
        test_fault_modes();
        test_hold();
        test_ignore_start();
        test_reset_midrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_selftest_ctrl.md
GATE_SELFTEST_CTRL -- requirements
Module: gate_selftest_ctrl

Interface
REQ-001 Parameter: SETTLE_CYCLES, 2, cycles each input vector is held before gate output is sampled; legal range 1..15.
REQ-002 Parameter: EXPECT, 4'b0111, expected gate output per vector; bit i = expected output for vector i, where i = {gate_a,gate_b}; default is the NAND truth table.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: start  input  1  level request to begin a self-test run; sampled only in IDLE.
REQ-006 Port: gate_a  output  1  drives gate input A.
REQ-007 Port: gate_b  output  1  drives gate input B.
REQ-008 Port: gate_c  input  1  gate output under test.
REQ-009 Port: busy  output  1  high while a run is in progress (SETTLE or CHECK).
REQ-010 Port: done  output  1  one-cycle pulse at run completion.
REQ-011 Port: pass  output  1  result of last completed run; 1 = all four vectors matched.
REQ-012 Port: fail_vec  output  2  index of first mismatching vector (see Configuration).
REQ-013 Port: fail_cnt  output  3  number of mismatching vectors, 0..4 (see Configuration).

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, CHECK, DONE.
REQ-015 IDLE: gate_a=gate_b=0; start=1 -> SETTLE with vector index 0, settle counter cleared, mismatch flags cleared; start=0 -> stay.
REQ-016 SETTLE: {gate_a,gate_b}=vector index; after exactly SETTLE_CYCLES cycles in SETTLE -> CHECK.
REQ-017 CHECK (1 cycle): gate_c compared with EXPECT[index]; mismatch recorded; index<3 -> index+1, SETTLE; index=3 -> DONE.
REQ-018 Vector inputs SHALL remain stable through SETTLE and CHECK of the same vector, changing only on the CHECK->SETTLE transition.
REQ-019 DONE (1 cycle): done=1, pass updated, gate_a=gate_b=0; then -> IDLE unconditionally.
REQ-020 Latency: start sampled in cycle 0 -> done high in cycle 1+4*(SETTLE_CYCLES+1); 13 for default.
REQ-021 start while busy or in DONE SHALL be ignored; start held high in IDLE after DONE starts a new run one cycle after DONE.
REQ-022 pass, fail_vec, fail_cnt SHALL hold their last values from DONE until the next DONE; they are not cleared by start.
REQ-023 busy SHALL be 1 exactly in SETTLE and CHECK.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE and zero gate_a, gate_b, busy, done, pass, fail_vec, fail_cnt, index, settle counter.
REQ-025 rst mid-run SHALL abort without asserting done; rst takes priority over start in the same cycle.

Configuration
REQ-026 Macro ERR_CAPTURE_EN defined: fail_vec SHALL hold the index of the first mismatching vector of the last run (0 if none), and fail_cnt the total count of mismatches, both updated in DONE.
REQ-027 Macro ERR_CAPTURE_EN undefined: fail_vec and fail_cnt SHALL be constant 0; ports remain present; pass behaviour unchanged.

Verification
REQ-028 Correct NAND gate on gate_c, default params, start pulse at cycle 0 -> vectors 00,01,10,11 in order, done at cycle 13, pass=1, fail_cnt=0.
REQ-029 gate_c stuck-at-1 -> pass=0; with ERR_CAPTURE_EN, fail_vec=3, fail_cnt=1.
REQ-030 gate_c stuck-at-0 -> pass=0; with ERR_CAPTURE_EN, fail_vec=0, fail_cnt=3; without it, both 0.
REQ-031 start pulsed again at cycles 4 and 8 during a run -> ignored, single done at cycle 13.
REQ-032 rst asserted at cycle 6 -> next cycle busy=0, gate_a=gate_b=0, no done; subsequent start -> full run, done 13 cycles later.
REQ-033 SETTLE_CYCLES=1, start held high continuously -> done at cycles 9, 19, 29 (back-to-back runs).
